safe_access_ctrl: RTL and testbench

Supervisory controller that sequences the three-button combination lock FSM (A, A, B unlock sequence, sticky unlocked state, async-reset). Debounces raw buttons, forwards clean single-cycle key pulses to the lock, judges each attempt, counts failures, enforces a lockout window, and auto-relocks the lock through its reset. Sits between the front-panel buttons and the lock instance.

---
 rtl/safe_pkg.sv | 29 ++
 rtl/key_debounce.sv | 64 ++++++
 rtl/safe_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_safe_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
// safe_pkg: shared types and constants for the safe access controller.
//   ctrl_state_t : supervisory FSM state encoding (also exported on state_dbg)
//   KEY_*        : bit positions of the {a,b,c} key vector
//   imax         : elaboration-time helper for sizing shared timers
package safe_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        RELOCK  = 3'd4,
        FAIL    = 3'd5,
        LOCKOUT = 3'd6
    } ctrl_state_t;

    localparam int KEY_W = 3;
    localparam int KEY_A = 2;
    localparam int KEY_B = 1;
    localparam int KEY_C = 0;

    // Only a lone C press closes the door early.
    localparam logic [KEY_W-1:0] KEY_RELOCK = 3'b001;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus per-bit debounce counter.
//   clk, rst    : clock, async active-high reset
//   i_raw [W]   : raw asynchronous button levels
//   o_level [W] : debounced level, moves only after DEBOUNCE_CYC equal synced samples
//   o_rise [W]  : one-cycle pulse in the cycle o_level rises
module key_debounce
    import safe_pkg::*;
#(
    parameter int W            = KEY_W,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_level,
    output logic [W-1:0] o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < W; g++) begin : g_bit
        logic [CW-1:0] r_cnt;
        logic          r_lvl;
        logic          r_rs;

        // Counter tracks how long the synced sample has disagreed with the
        // debounced level; any agreeing sample restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
                r_rs  <= 1'b0;
            end else begin
                r_rs <= 1'b0;
                if (r_sync2[g] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    r_cnt <= '0;
                    r_lvl <= r_sync2[g];
                    r_rs  <= r_sync2[g];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign o_level[g] = r_lvl;
        assign o_rise[g]  = r_rs;
    end

endmodule

// File: rtl/safe_access_ctrl.sv
// safe_access_ctrl: supervisor between front-panel buttons and the A,A,B lock FSM.
//   clk, rst              : clock, async active-high reset
//   btn_a/b/c             : raw buttons
//   lock_unlock           : unlock flag from the lock FSM
//   lock_a/b/c            : one-cycle key pulses to the lock
//   lock_rst              : registered reset to the lock (high during reset)
//   door_open, lockout    : status
//   fail_cnt              : consecutive failed attempts
//   state_dbg             : current ctrl_state_t encoding
module safe_access_ctrl
    import safe_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CODE_LEN     = 3,
    parameter int CHECK_CYC    = 2,
    parameter int ENTRY_TO_CYC = 64,
    parameter int MAX_FAILS    = 3,
    parameter int LOCKOUT_CYC  = 16,
    parameter int RELOCK_CYC   = 32,
    localparam int FCW         = $clog2(MAX_FAILS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_a,
    input  logic           btn_b,
    input  logic           btn_c,
    input  logic           lock_unlock,
    output logic           lock_a,
    output logic           lock_b,
    output logic           lock_c,
    output logic           lock_rst,
    output logic           door_open,
    output logic           lockout,
    output logic [FCW-1:0] fail_cnt,
    output logic [2:0]     state_dbg
);

    localparam int PCW     = $clog2(CODE_LEN + 1);
    localparam int TMR_MAX = imax(imax(ENTRY_TO_CYC, CHECK_CYC), imax(LOCKOUT_CYC, RELOCK_CYC));
    localparam int TW      = $clog2(TMR_MAX + 1);

    logic [KEY_W-1:0] w_btn;
    logic [KEY_W-1:0] w_lvl;
    logic [KEY_W-1:0] w_rise;
    logic             w_evt;

    assign w_btn[KEY_A] = btn_a;
    assign w_btn[KEY_B] = btn_b;
    assign w_btn[KEY_C] = btn_c;

    key_debounce #(
        .W            (KEY_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (w_btn),
        .o_level (w_lvl),
        .o_rise  (w_rise)
    );

    // Any debounced rising edge is one press; the key value is the whole
    // debounced vector so chords pass through unchanged.
    assign w_evt = |w_rise;

    ctrl_state_t      r_state;
    ctrl_state_t      w_nxt;
    logic [PCW-1:0]   r_press_cnt;
    logic [PCW-1:0]   w_cnt_nxt;
    logic             w_fwd;
    logic [TW-1:0]    r_tmr;
    logic [FCW-1:0]   r_fail_cnt;
    logic [KEY_W-1:0] r_lock_key;
    logic             r_lock_rst;
    logic             r_door;
    logic             r_lockout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt     = r_state;
        w_fwd     = 1'b0;
        w_cnt_nxt = r_press_cnt;
        case (r_state)
            IDLE: begin
                if (w_evt) begin
                    w_fwd     = 1'b1;
                    w_cnt_nxt = PCW'(1);
                    w_nxt     = (w_cnt_nxt == PCW'(CODE_LEN)) ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                // Timeout checked first so a coincident press is dropped.
                if (r_tmr == TW'(ENTRY_TO_CYC - 1)) begin
                    w_nxt = FAIL;
                end else if (w_evt) begin
                    w_fwd     = 1'b1;
                    w_cnt_nxt = r_press_cnt + 1'b1;
                    if (w_cnt_nxt == PCW'(CODE_LEN)) w_nxt = CHECK;
                end
            end
            CHECK: begin
                if (lock_unlock)                        w_nxt = OPEN;
                else if (r_tmr == TW'(CHECK_CYC - 1))   w_nxt = FAIL;
            end
            OPEN: begin
                if ((w_evt && (w_lvl == KEY_RELOCK)) || (r_tmr == TW'(RELOCK_CYC - 1)))
                    w_nxt = RELOCK;
            end
            RELOCK:  w_nxt = IDLE;
            FAIL:    w_nxt = (r_fail_cnt == FCW'(MAX_FAILS)) ? LOCKOUT : IDLE;
            LOCKOUT: if (r_tmr == TW'(LOCKOUT_CYC - 1)) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // One shared timer: cleared on every state change and on every forwarded
    // press (so ENTRY measures idle time between presses), saturates otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press_cnt <= '0;
            r_tmr       <= '0;
            r_fail_cnt  <= '0;
            r_lock_key  <= '0;
            r_lock_rst  <= 1'b1;
            r_door      <= 1'b0;
            r_lockout   <= 1'b0;
        end else begin
            r_press_cnt <= w_cnt_nxt;
            if ((w_nxt != r_state) || w_fwd) r_tmr <= '0;
            else if (r_tmr != '1)            r_tmr <= r_tmr + 1'b1;

            // Count moves on the edge entering FAIL/RELOCK so it is valid
            // alongside the lock_rst pulse; lockout clears it on exit.
            if ((w_nxt == FAIL) && (r_state != FAIL)) begin
                if (r_fail_cnt != FCW'(MAX_FAILS)) r_fail_cnt <= r_fail_cnt + 1'b1;
            end else if ((w_nxt == RELOCK) && (r_state != RELOCK)) begin
                r_fail_cnt <= '0;
            end else if ((r_state == LOCKOUT) && (w_nxt == IDLE)) begin
                r_fail_cnt <= '0;
            end

            r_lock_key <= w_fwd ? w_lvl : '0;
            r_lock_rst <= (w_nxt == RELOCK) || (w_nxt == FAIL);
            r_door     <= (w_nxt == OPEN);
            r_lockout  <= (w_nxt == LOCKOUT);
        end
    end

    assign lock_a    = r_lock_key[KEY_A];
    assign lock_b    = r_lock_key[KEY_B];
    assign lock_c    = r_lock_key[KEY_C];
    assign lock_rst  = r_lock_rst;
    assign door_open = r_door;
    assign lockout   = r_lockout;
    assign fail_cnt  = r_fail_cnt;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_safe_access_ctrl.sv
// Bench for safe_access_ctrl with a behavioural A,A,B lock and an
// event scoreboard (key pulses, lock_rst cycles, door/lockout windows).
module tb_safe_access_ctrl;

    localparam int DEB      = 4;
    localparam int MAXF     = 3;
    localparam int LOCK_CYC = 16;
    localparam int RELOCK_T = 32;
    localparam int ETO      = 64;

    localparam int EV_KEY  = 1;
    localparam int EV_RST  = 2;
    localparam int EV_OPEN = 3;
    localparam int EV_LOUT = 4;

    localparam logic [2:0] KA = 3'b100;
    localparam logic [2:0] KB = 3'b010;
    localparam logic [2:0] KC = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_a, btn_b, btn_c;
    logic       lock_unlock;
    logic       lock_a, lock_b, lock_c, lock_rst;
    logic       door_open, lockout;
    logic [1:0] fail_cnt;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    safe_access_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .CODE_LEN     (3),
        .CHECK_CYC    (2),
        .ENTRY_TO_CYC (ETO),
        .MAX_FAILS    (MAXF),
        .LOCKOUT_CYC  (LOCK_CYC),
        .RELOCK_CYC   (RELOCK_T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_a       (btn_a),
        .btn_b       (btn_b),
        .btn_c       (btn_c),
        .lock_unlock (lock_unlock),
        .lock_a      (lock_a),
        .lock_b      (lock_b),
        .lock_c      (lock_c),
        .lock_rst    (lock_rst),
        .door_open   (door_open),
        .lockout     (lockout),
        .fail_cnt    (fail_cnt),
        .state_dbg   (state_dbg)
    );

    // Behavioural lock: A,A,B opens, wrong key restarts, S3 sticky.
    logic [1:0] ls;
    always @(posedge clk or posedge lock_rst) begin
        if (lock_rst) ls <= 2'd0;
        else begin
            case (ls)
                2'd0: if ({lock_a, lock_b, lock_c} == KA) ls <= 2'd1;
                2'd1: if ({lock_a, lock_b, lock_c} == KA) ls <= 2'd2;
                      else if ({lock_a, lock_b, lock_c} != 3'b000) ls <= 2'd0;
                2'd2: if ({lock_a, lock_b, lock_c} == KB) ls <= 2'd3;
                      else if ({lock_a, lock_b, lock_c} != 3'b000) ls <= 2'd0;
                default: ls <= 2'd3;
            endcase
        end
    end
    assign lock_unlock = (ls == 2'd3);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } ev_t;

    ev_t   sbq[$];
    int    n_chk    = 0;
    int    n_err    = 0;
    int    exp_fail = 0;
    bit    mon_en   = 1'b0;
    string kn[5]    = '{"none", "key", "rst", "open", "lockout"};

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int d);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = d;
        sbq.push_back(e);
    endtask

    // Match the oldest expected entry of the same kind.
    task automatic sb_pop(input int kind, input int c, input int d);
        int idx;
        idx = -1;
        foreach (sbq[i]) if (idx < 0 && sbq[i].kind == kind) idx = i;
        if (idx < 0) begin
            chk($sformatf("unexpected_%s@%0d", kn[kind], c), kind, 0);
        end else begin
            chk($sformatf("%s_cyc", kn[kind]), c, sbq[idx].cyc);
            chk($sformatf("%s_data", kn[kind]), d, sbq[idx].data);
            sbq.delete(idx);
        end
    endtask

    // Monitor: key pulses and lock_rst per high cycle; door/lockout as
    // (start cycle, width) on their falling edge.
    initial begin : mon
        bit door_q = 1'b0;
        bit lo_q   = 1'b0;
        int door_s = 0;
        int lo_s   = 0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (lock_a | lock_b | lock_c) sb_pop(EV_KEY, cyc, {lock_a, lock_b, lock_c});
                if (lock_rst) sb_pop(EV_RST, cyc, fail_cnt);
                if (door_open && !door_q) door_s = cyc;
                if (!door_open && door_q) sb_pop(EV_OPEN, door_s, cyc - door_s);
                if (lockout && !lo_q) lo_s = cyc;
                if (!lockout && lo_q) sb_pop(EV_LOUT, lo_s, cyc - lo_s);
            end
            door_q = door_open;
            lo_q   = lockout;
        end
    end

    // Drive a press; pulse (if forwarded) lands DEB+2 edges after the first sampling edge.
    task automatic press_go(input logic [2:0] bits, input bit fwd, output int pc);
        @(posedge clk);
        #1;
        {btn_a, btn_b, btn_c} = bits;
        pc = cyc + 1 + 2 + DEB;
        if (fwd) push(EV_KEY, pc, bits);
    endtask

    task automatic press_done(input int hold);
        repeat (hold) @(posedge clk);
        #1;
        {btn_a, btn_b, btn_c} = 3'b000;
        repeat (10) @(posedge clk);
    endtask

    task automatic attempt(input logic [2:0] k0, input logic [2:0] k1, input logic [2:0] k2,
                           input bit ok, output int t);
        int p;
        press_go(k0, 1'b1, p);
        press_done(6);
        press_go(k1, 1'b1, p);
        press_done(6);
        press_go(k2, 1'b1, t);
        if (!ok) begin
            exp_fail++;
            push(EV_RST, t + 2, exp_fail);
            if (exp_fail == MAXF) push(EV_LOUT, t + 3, LOCK_CYC);
        end
        press_done(6);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int t;
        int p;
        rst = 1'b1;
        {btn_a, btn_b, btn_c} = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lock_rst", lock_rst, 1);
        chk("rst_keys", {lock_a, lock_b, lock_c}, 0);
        chk("rst_door", door_open, 0);
        chk("rst_lockout", lockout, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_state", state_dbg, 0);
        rst = 1'b0;
        #1;
        chk("rst_hold", lock_rst, 1);
        @(posedge clk);
        #1;
        chk("rst_drop", lock_rst, 0);
        mon_en = 1'b1;

        // A,A,B opens; idle relock after RELOCK_T cycles
        attempt(KA, KA, KB, 1'b1, t);
        push(EV_OPEN, t + 2, RELOCK_T);
        push(EV_RST, t + 2 + RELOCK_T, 0);
        chk("open_door", door_open, 1);
        chk("open_state", state_dbg, 3);
        chk("open_fail", fail_cnt, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("idle_relock_door", door_open, 0);

        // A,B,B fails once
        attempt(KA, KB, KB, 1'b0, t);
        chk("fail1_cnt", fail_cnt, 1);
        chk("fail1_door", door_open, 0);

        // Open again, C press relocks early and clears fail_cnt
        attempt(KA, KA, KB, 1'b1, t);
        press_go(KC, 1'b0, p);
        push(EV_OPEN, t + 2, p - (t + 2));
        push(EV_RST, p, 0);
        press_done(6);
        exp_fail = 0;
        chk("crelock_fail", fail_cnt, 0);
        chk("crelock_door", door_open, 0);

        // Three wrong attempts -> lockout; press inside is dropped
        attempt(KA, KB, KB, 1'b0, t);
        attempt(KB, KA, KA, 1'b0, t);
        attempt(KC, KC, KC, 1'b0, t);
        chk("lout_active", lockout, 1);
        press_go(KA, 1'b0, p);
        press_done(6);
        exp_fail = 0;
        chk("lout_exit_fail", fail_cnt, 0);
        chk("lout_exit_state", state_dbg, 0);

        // 2-cycle glitch ignored; 6-cycle press forwarded, then entry timeout
        press_go(KA, 1'b0, p);
        press_done(2);
        chk("glitch_state", state_dbg, 0);
        press_go(KA, 1'b1, p);
        push(EV_RST, p + ETO, exp_fail + 1);
        press_done(6);
        chk("entry_state", state_dbg, 1);
        repeat (70) @(posedge clk);
        #1;
        exp_fail = 1;
        chk("timeout_fail", fail_cnt, 1);
        chk("timeout_state", state_dbg, 0);

        // Reset after two A presses
        press_go(KA, 1'b1, p);
        press_done(6);
        press_go(KA, 1'b1, p);
        press_done(6);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_lock_rst", lock_rst, 1);
        chk("mid_rst_fail", fail_cnt, 0);
        chk("mid_rst_state", state_dbg, 0);
        chk("mid_rst_keys", {lock_a, lock_b, lock_c, door_open, lockout}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_drop", lock_rst, 0);
        mon_en = 1'b1;
        exp_fail = 0;

        attempt(KA, KA, KB, 1'b1, t);
        chk("post_rst_open", door_open, 1);
        press_go(KC, 1'b0, p);
        push(EV_OPEN, t + 2, p - (t + 2));
        push(EV_RST, p, 0);
        press_done(6);
        chk("post_rst_door", door_open, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
